// File: rtl/dmem_arbiter_if.sv
// Request/response channel between one requester and the data-memory arbiter.
// The requester drives the master side; the arbiter drives the slave side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
    logic              gnt;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, funct3,
        input  gnt, done, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata, funct3,
        output gnt, done, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-addressed data memory.
// One access every two cycles: grant (IDLE), memory access (ACCESS), registered completion.
module dmem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int PRIO_INIT   = 0,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state, state_next;
    logic              prio;
    logic [1:0]        gnt;
    logic              sel;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_funct3;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_funct3;
    logic              lat_port;
    logic              lat_err;

    logic [1:0]        done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    // Illegal size/sign code, or a half/word not on its natural boundary.
    // Natural alignment also guarantees a multi-byte access never wraps the top address.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [ADDR_W-1:0] addr);
        logic legal;
        logic misaligned;
        if (we) legal = f3 inside {3'b000, 3'b001, 3'b010};
        else    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned = 1'b0;
        if (CHECK_ALIGN != 0) begin
            case (f3[1:0])
                2'b01:   misaligned = addr[0];
                2'b10:   misaligned = addr[1] | addr[0];
                default: misaligned = 1'b0;
            endcase
        end
        return !legal || misaligned;
    endfunction

    // On a tie the port holding priority wins; a lone requester always wins.
    always_comb begin
        if (r0.req && r1.req) sel = prio;
        else                  sel = r1.req;
    end

    assign sel_we     = sel ? r1.we     : r0.we;
    assign sel_addr   = sel ? r1.addr   : r0.addr;
    assign sel_wdata  = sel ? r1.wdata  : r0.wdata;
    assign sel_funct3 = sel ? r1.funct3 : r0.funct3;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        gnt        = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = 3'b000;
        case (state)
            IDLE: begin
                if (rst_n && (r0.req || r1.req)) begin
                    gnt[sel]   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_read   = !lat_we && !lat_err;
                mem_write  = lat_we && !lat_err;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                mem_funct3 = lat_funct3;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'(PRIO_INIT);
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= 3'b000;
            lat_port   <= 1'b0;
            lat_err    <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state  <= state_next;
            done_q <= 2'b00;
            if (state == IDLE && gnt != 2'b00) begin
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                lat_funct3 <= sel_funct3;
                lat_port   <= sel;
                lat_err    <= access_err(sel_we, sel_funct3, sel_addr);
                prio       <= ~sel;
            end
            // Completion is reported in the cycle after ACCESS, overlapping the next grant.
            if (state == ACCESS) begin
                done_q[lat_port] <= 1'b1;
                err_q            <= lat_err;
                rdata_q          <= (!lat_we && !lat_err) ? mem_rdata : '0;
            end
        end
    end

    assign r0.gnt   = gnt[0];
    assign r1.gnt   = gnt[1];
    assign r0.done  = done_q[0];
    assign r1.done  = done_q[1];
    assign r0.err   = done_q[0] & err_q;
    assign r1.err   = done_q[1] & err_q;
    assign r0.rdata = done_q[0] ? rdata_q : '0;
    assign r1.rdata = done_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a little-endian byte memory model, a vector table
// of single accesses, and hand-written sequences for tie, reset and withdrawn-request cases.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) r0 ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) r1 ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) n0 ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) n1 ();

    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    logic        na_mem_read, na_mem_write;
    logic [7:0]  na_mem_addr;
    logic [31:0] na_mem_wdata;
    logic [2:0]  na_mem_funct3;
    logic [31:0] na_mem_rdata = 32'h0000_ABCD;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .PRIO_INIT(0), .CHECK_ALIGN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .r0(r0), .r1(r1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .PRIO_INIT(0), .CHECK_ALIGN(0)) u_dut_na (
        .clk(clk), .rst_n(rst_n), .r0(n0), .r1(n1),
        .mem_read(na_mem_read), .mem_write(na_mem_write), .mem_addr(na_mem_addr),
        .mem_wdata(na_mem_wdata), .mem_funct3(na_mem_funct3), .mem_rdata(na_mem_rdata)
    );

    // Behavioural data memory: combinational sized/sign-extended read, store on clock edge.
    logic [7:0] mem [256];
    logic [7:0] a1, a2, a3;
    assign a1 = mem_addr + 8'd1;
    assign a2 = mem_addr + 8'd2;
    assign a3 = mem_addr + 8'd3;

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
            3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[mem_addr]};
            3'b010:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
            3'b100:  mem_rdata = {24'h0, mem[mem_addr]};
            3'b101:  mem_rdata = {16'h0, mem[a1], mem[mem_addr]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_funct3 == 3'b001 || mem_funct3 == 3'b010) mem[a1] <= mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        if (p == 0) begin
            r0.req = req; r0.we = we; r0.addr = addr; r0.wdata = wdata; r0.funct3 = f3;
        end else begin
            r1.req = req; r1.we = we; r1.addr = addr; r1.wdata = wdata; r1.funct3 = f3;
        end
    endtask

    function automatic logic get_gnt(input int p);
        return (p == 0) ? r0.gnt : r1.gnt;
    endfunction
    function automatic logic get_done(input int p);
        return (p == 0) ? r0.done : r1.done;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? r0.err : r1.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? r0.rdata : r1.rdata;
    endfunction

    // One isolated access from IDLE: grant now, memory access next cycle, done the cycle after.
    task automatic do_access(input string name, input int p, input logic we,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, input logic exp_err,
                             input logic [31:0] exp_rdata);
        drive(p, 1'b1, we, addr, wdata, f3);
        #1;
        check({name, " gnt"}, 32'(get_gnt(p)), 32'd1);
        tick();
        drive(p, 1'b0, 1'b0, 8'hFF, 32'hFFFF_FFFF, 3'b111);
        #1;
        check({name, " mem_read"},  32'(mem_read),  32'(!we && !exp_err));
        check({name, " mem_write"}, 32'(mem_write), 32'(we && !exp_err));
        if (!exp_err) begin
            check({name, " mem_addr"},   32'(mem_addr),   32'(addr));
            check({name, " mem_funct3"}, 32'(mem_funct3), 32'(f3));
            if (we) check({name, " mem_wdata"}, mem_wdata, wdata);
        end
        tick();
        #1;
        check({name, " done"},       32'(get_done(p)),     32'd1);
        check({name, " other done"}, 32'(get_done(1 - p)), 32'd0);
        check({name, " err"},        32'(get_err(p)),      32'(exp_err));
        check({name, " rdata"},      get_rdata(p),         exp_rdata);
        check({name, " mem idle"},   32'(mem_read | mem_write), 32'd0);
        tick();
        #1;
        check({name, " done drop"},  32'(get_done(p)),     32'd0);
    endtask

    typedef struct {
        string       name;
        int          port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    // Expected {gnt0, gnt1, done0, done1} per cycle with both requests held.
    logic [3:0] tie_exp [9];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        n0.req = 1'b0; n0.we = 1'b0; n0.addr = 8'h00; n0.wdata = 32'h0; n0.funct3 = 3'b000;
        n1.req = 1'b0; n1.we = 1'b0; n1.addr = 8'h00; n1.wdata = 32'h0; n1.funct3 = 3'b000;

        vecs[0]  = '{"sw 10",        0, 1'b1, 8'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0};
        vecs[1]  = '{"lw 10",        0, 1'b0, 8'h10, 32'h0,         3'b010, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{"sb 20",        1, 1'b1, 8'h20, 32'h0000_0080, 3'b000, 1'b0, 32'h0};
        vecs[3]  = '{"lb 20",        0, 1'b0, 8'h20, 32'h0,         3'b000, 1'b0, 32'hFFFF_FF80};
        vecs[4]  = '{"lbu 20",       1, 1'b0, 8'h20, 32'h0,         3'b100, 1'b0, 32'h0000_0080};
        vecs[5]  = '{"sh 22",        0, 1'b1, 8'h22, 32'h0000_8001, 3'b001, 1'b0, 32'h0};
        vecs[6]  = '{"lh 22",        1, 1'b0, 8'h22, 32'h0,         3'b001, 1'b0, 32'hFFFF_8001};
        vecs[7]  = '{"lhu 22",       0, 1'b0, 8'h22, 32'h0,         3'b101, 1'b0, 32'h0000_8001};
        vecs[8]  = '{"lw 02 misal",  0, 1'b0, 8'h02, 32'h0,         3'b010, 1'b1, 32'h0};
        vecs[9]  = '{"sw f3 011",    1, 1'b1, 8'h10, 32'h1111_1111, 3'b011, 1'b1, 32'h0};
        vecs[10] = '{"lw 10 again",  1, 1'b0, 8'h10, 32'h0,         3'b010, 1'b0, 32'hDEAD_BEEF};
        vecs[11] = '{"load f3 110",  0, 1'b0, 8'h10, 32'h0,         3'b110, 1'b1, 32'h0};
        vecs[12] = '{"sh 23 misal",  1, 1'b1, 8'h23, 32'h0000_FFFF, 3'b001, 1'b1, 32'h0};
        vecs[13] = '{"sw 30",        0, 1'b1, 8'h30, 32'hCAFE_F00D, 3'b010, 1'b0, 32'h0};
        vecs[14] = '{"lw 30",        1, 1'b0, 8'h30, 32'h0,         3'b010, 1'b0, 32'hCAFE_F00D};

        tie_exp[0] = 4'b1000; tie_exp[1] = 4'b0000; tie_exp[2] = 4'b0110;
        tie_exp[3] = 4'b0000; tie_exp[4] = 4'b1001; tie_exp[5] = 4'b0000;
        tie_exp[6] = 4'b0110; tie_exp[7] = 4'b0000; tie_exp[8] = 4'b0001;

        // Reset state
        tick();
        tick();
        check("reset mem ctrl", {30'h0, mem_read, mem_write}, 32'h0);
        check("reset mem addr", {24'h0, mem_addr}, 32'h0);
        check("reset mem wdata", mem_wdata, 32'h0);
        check("reset done/err", {28'h0, r0.done, r1.done, r0.err, r1.err}, 32'h0);
        check("reset rdata", r0.rdata | r1.rdata, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        // Tie from reset priority: grants alternate 0,1,0,1 every 2 cycles
        drive(0, 1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 8'h04, 32'h0, 3'b010);
        #1;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("tie cycle %0d g0g1d0d1", c),
                  {28'h0, r0.gnt, r1.gnt, r0.done, r1.done}, {28'h0, tie_exp[c]});
            if (c == 7) begin
                drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
                drive(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
            end
            tick();
            #1;
        end

        // Table of isolated accesses
        for (int i = 0; i < 15; i++) begin
            do_access(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].f3, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset during ACCESS of a store: write must not commit, no done afterwards
        drive(0, 1'b1, 1'b1, 8'h30, 32'h1234_5678, 3'b010);
        #1;
        check("rst-mid gnt", 32'(r0.gnt), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        #1;
        check("rst-mid pre mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst-mid mem ctrl", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst-mid mem addr/wdata", {24'h0, mem_addr} | mem_wdata, 32'h0);
        tick();
        #1;
        check("rst-mid done held", {30'h0, r0.done, r1.done}, 32'h0);
        rst_n = 1'b1;
        tick();
        #1;
        check("rst-mid done after", {30'h0, r0.done, r1.done}, 32'h0);
        do_access("rst-mid lw 30", 0, 1'b0, 8'h30, 32'h0, 3'b010, 1'b0, 32'hCAFE_F00D);

        // Port 1 request pulses only during port 0's ACCESS cycle
        drive(0, 1'b1, 1'b0, 8'h10, 32'h0, 3'b010);
        #1;
        check("wd gnt0", 32'(r0.gnt), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        drive(1, 1'b1, 1'b1, 8'h10, 32'h5555_5555, 3'b010);
        #1;
        check("wd gnt1 in access", 32'(r1.gnt), 32'd0);
        #3;
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        tick();
        #1;
        check("wd done0", 32'(r0.done), 32'd1);
        check("wd rdata0", r0.rdata, 32'hDEAD_BEEF);
        check("wd gnt1 after", 32'(r1.gnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check($sformatf("wd quiet %0d", c),
                  {29'h0, r1.done, mem_read, mem_write}, 32'h0);
        end
        do_access("wd lw 10", 1, 1'b0, 8'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);

        // Alignment checking disabled: misaligned half passes through
        n0.req = 1'b1; n0.we = 1'b0; n0.addr = 8'h01; n0.funct3 = 3'b001;
        #1;
        check("na gnt", 32'(n0.gnt), 32'd1);
        tick();
        n0.req = 1'b0;
        #1;
        check("na mem_read", 32'(na_mem_read), 32'd1);
        check("na mem_addr", 32'(na_mem_addr), 32'h01);
        tick();
        #1;
        check("na done", 32'(n0.done), 32'd1);
        check("na err", 32'(n0.err), 32'd0);
        check("na rdata", n0.rdata, 32'h0000_ABCD);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
